// File: rtl/bip_pkg.sv
// bip_pkg: opcode map, datapath select encodings and FSM states for the BIP fetch/decode unit
package bip_pkg;

   localparam int OPC_WIDTH = 5;

   localparam logic [OPC_WIDTH-1:0] OPC_HALT = 5'b00000;
   localparam logic [OPC_WIDTH-1:0] OPC_STO  = 5'b00001;
   localparam logic [OPC_WIDTH-1:0] OPC_LD   = 5'b00010;
   localparam logic [OPC_WIDTH-1:0] OPC_LDI  = 5'b00011;
   localparam logic [OPC_WIDTH-1:0] OPC_ADD  = 5'b00100;
   localparam logic [OPC_WIDTH-1:0] OPC_ADDI = 5'b00101;
   localparam logic [OPC_WIDTH-1:0] OPC_SUB  = 5'b00110;
   localparam logic [OPC_WIDTH-1:0] OPC_SUBI = 5'b00111;

   localparam logic [1:0] SEL_A_RAM = 2'd0;
   localparam logic [1:0] SEL_A_IMM = 2'd1;
   localparam logic [1:0] SEL_A_ALU = 2'd2;

   localparam logic SEL_B_RAM = 1'b0;
   localparam logic SEL_B_IMM = 1'b1;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

endpackage

// File: rtl/bip_decoder.sv
// bip_decoder: combinational opcode to datapath-control decode
module bip_decoder
   import bip_pkg::*;
(
   input  logic [OPC_WIDTH-1:0] i_opc,
   output logic [1:0]           o_sel_a,
   output logic                 o_sel_b,
   output logic                 o_op_sub,
   output logic                 o_wr_acc,
   output logic                 o_rd_ram,
   output logic                 o_wr_ram,
   output logic                 o_is_halt,
   output logic                 o_illegal
);

   // map each opcode to its control set; anything unlisted is an illegal NOP
   always_comb begin
      o_sel_a   = SEL_A_RAM;
      o_sel_b   = SEL_B_RAM;
      o_op_sub  = 1'b0;
      o_wr_acc  = 1'b0;
      o_rd_ram  = 1'b0;
      o_wr_ram  = 1'b0;
      o_is_halt = 1'b0;
      o_illegal = 1'b0;
      case (i_opc)
         OPC_HALT: o_is_halt = 1'b1;
         OPC_STO:  o_wr_ram  = 1'b1;
         OPC_LD: begin
            o_rd_ram = 1'b1;
            o_sel_a  = SEL_A_RAM;
            o_wr_acc = 1'b1;
         end
         OPC_LDI: begin
            o_sel_a  = SEL_A_IMM;
            o_wr_acc = 1'b1;
         end
         OPC_ADD: begin
            o_rd_ram = 1'b1;
            o_sel_a  = SEL_A_ALU;
            o_sel_b  = SEL_B_RAM;
            o_wr_acc = 1'b1;
         end
         OPC_ADDI: begin
            o_sel_a  = SEL_A_ALU;
            o_sel_b  = SEL_B_IMM;
            o_wr_acc = 1'b1;
         end
         OPC_SUB: begin
            o_rd_ram = 1'b1;
            o_sel_a  = SEL_A_ALU;
            o_sel_b  = SEL_B_RAM;
            o_op_sub = 1'b1;
            o_wr_acc = 1'b1;
         end
         OPC_SUBI: begin
            o_sel_a  = SEL_A_ALU;
            o_sel_b  = SEL_B_IMM;
            o_op_sub = 1'b1;
            o_wr_acc = 1'b1;
         end
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/bip_fetch_control.sv
// bip_fetch_control: two-cycle fetch/exec FSM owning PC, HALT and the registered control strobes
module bip_fetch_control
   import bip_pkg::*;
#(
   parameter int PC_WIDTH    = 11,
   parameter int INSTR_WIDTH = 16,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   run,
   output logic [PC_WIDTH-1:0]    prog_addr,
   input  logic [INSTR_WIDTH-1:0] prog_data,
   output logic [PC_WIDTH-1:0]    operand,
   output logic [1:0]             sel_a,
   output logic                   sel_b,
   output logic                   op_sub,
   output logic                   wr_acc,
   output logic                   rd_ram,
   output logic                   wr_ram,
   output logic                   halted,
   output logic                   illegal_op,
   output logic [CNT_WIDTH-1:0]   instr_count
);

   state_t                r_state;
   logic [PC_WIDTH-1:0]   r_pc;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [PC_WIDTH-1:0]   r_operand;
   logic [1:0]            r_sel_a;
   logic                  r_sel_b;
   logic                  r_op_sub;
   logic                  r_wr_acc;
   logic                  r_rd_ram;
   logic                  r_wr_ram;
   logic                  r_halted;
   logic                  r_illegal;

   logic [1:0]            w_sel_a;
   logic                  w_sel_b;
   logic                  w_op_sub;
   logic                  w_wr_acc;
   logic                  w_rd_ram;
   logic                  w_wr_ram;
   logic                  w_is_halt;
   logic                  w_illegal;

   bip_decoder u_dec (
      .i_opc    (prog_data[INSTR_WIDTH-1 -: OPC_WIDTH]),
      .o_sel_a  (w_sel_a),
      .o_sel_b  (w_sel_b),
      .o_op_sub (w_op_sub),
      .o_wr_acc (w_wr_acc),
      .o_rd_ram (w_rd_ram),
      .o_wr_ram (w_wr_ram),
      .o_is_halt(w_is_halt),
      .o_illegal(w_illegal)
   );

   // FSM plus output stage: controls are captured from the word decoded in EXEC and last one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_FETCH;
         r_pc      <= '0;
         r_cnt     <= '0;
         r_operand <= '0;
         r_sel_a   <= '0;
         r_sel_b   <= 1'b0;
         r_op_sub  <= 1'b0;
         r_wr_acc  <= 1'b0;
         r_rd_ram  <= 1'b0;
         r_wr_ram  <= 1'b0;
         r_halted  <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_sel_a   <= '0;
         r_sel_b   <= 1'b0;
         r_op_sub  <= 1'b0;
         r_wr_acc  <= 1'b0;
         r_rd_ram  <= 1'b0;
         r_wr_ram  <= 1'b0;
         r_illegal <= 1'b0;
         case (r_state)
            ST_FETCH: r_state <= run ? ST_EXEC : ST_FETCH;
            ST_EXEC: begin
               r_sel_a   <= w_sel_a;
               r_sel_b   <= w_sel_b;
               r_op_sub  <= w_op_sub;
               r_wr_acc  <= w_wr_acc;
               r_rd_ram  <= w_rd_ram;
               r_wr_ram  <= w_wr_ram;
               r_illegal <= w_illegal;
               r_operand <= prog_data[PC_WIDTH-1:0];
               r_cnt     <= r_cnt + 1'b1;
               r_halted  <= w_is_halt;
               r_state   <= w_is_halt ? ST_HALT : ST_FETCH;
               r_pc      <= w_is_halt ? r_pc : r_pc + 1'b1;
            end
            default: r_state <= ST_HALT;
         endcase
      end
   end

   assign prog_addr   = r_pc;
   assign operand     = r_operand;
   assign sel_a       = r_sel_a;
   assign sel_b       = r_sel_b;
   assign op_sub      = r_op_sub;
   assign wr_acc      = r_wr_acc;
   assign rd_ram      = r_rd_ram;
   assign wr_ram      = r_wr_ram;
   assign halted      = r_halted;
   assign illegal_op  = r_illegal;
   assign instr_count = r_cnt;

endmodule

// File: tb/tb_bip_fetch_control.sv
// tb_bip_fetch_control: instruction-level model plus directed programs for the BIP fetch/decode unit
module tb_bip_fetch_control;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic [10:0] prog_addr;
   logic [15:0] prog_data = '0;
   logic [10:0] operand;
   logic [1:0]  sel_a;
   logic        sel_b, op_sub, wr_acc, rd_ram, wr_ram, halted, illegal_op;
   logic [15:0] instr_count;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   bip_fetch_control dut (
      .clk(clk), .rst(rst), .run(run),
      .prog_addr(prog_addr), .prog_data(prog_data),
      .operand(operand), .sel_a(sel_a), .sel_b(sel_b), .op_sub(op_sub),
      .wr_acc(wr_acc), .rd_ram(rd_ram), .wr_ram(wr_ram),
      .halted(halted), .illegal_op(illegal_op), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [2048];

   always @(posedge clk) prog_data <= mem[prog_addr];

   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   // {sel_a, sel_b, op_sub, wr_acc, rd_ram, wr_ram, illegal}
   function automatic logic [7:0] ctl(input logic [4:0] opc);
      case (opc)
         5'd0: return 8'b00_0_0_0_0_0_0;
         5'd1: return 8'b00_0_0_0_0_1_0;
         5'd2: return 8'b00_0_0_1_1_0_0;
         5'd3: return 8'b01_0_0_1_0_0_0;
         5'd4: return 8'b10_0_0_1_1_0_0;
         5'd5: return 8'b10_1_0_1_0_0_0;
         5'd6: return 8'b10_0_1_1_1_0_0;
         5'd7: return 8'b10_1_1_1_0_0_0;
         default: return 8'b00_0_0_0_0_0_1;
      endcase
   endfunction

   // model: phase 0 = waiting to fetch, 1 = word arriving, 2 = stopped
   int          m_ph = 0;
   logic [10:0] m_pc = '0;
   logic [15:0] m_cnt = '0;
   logic [10:0] m_opnd = '0;
   logic [7:0]  m_ctl = '0;
   logic        en = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_ph <= 0; m_pc <= '0; m_cnt <= '0; m_opnd <= '0; m_ctl <= '0; en <= 1'b1;
      end else if (en) begin
         m_ctl <= '0;
         if (m_ph == 1) begin
            m_ctl  <= ctl(mem[m_pc][15:11]);
            m_opnd <= mem[m_pc][10:0];
            m_cnt  <= m_cnt + 16'd1;
            m_ph   <= (mem[m_pc][15:11] == 5'd0) ? 2 : 0;
            if (mem[m_pc][15:11] != 5'd0) m_pc <= m_pc + 11'd1;
         end else if (m_ph == 0 && run) m_ph <= 1;
      end
   end

   logic [46:0] act, exp_v;
   always @(negedge clk) begin
      if (en) begin
         act   = {prog_addr, operand, sel_a, sel_b, op_sub, wr_acc, rd_ram, wr_ram, halted, illegal_op, instr_count};
         exp_v = {m_pc, m_opnd, m_ctl[7:1], m_ph == 2, m_ctl[0], m_cnt};
         total++;
         if (act !== exp_v) begin
            bad++;
            $display("FAIL cycle %0d outputs got=%h exp=%h", cyc, act, exp_v);
         end
      end
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", n, a, e);
      end
   endtask

   task automatic do_reset(input logic r);
      @(negedge clk);
      rst = 1'b1;
      run = r;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic at_cyc(input int k);
      int g = 0;
      @(negedge clk);
      while (cyc < k && g < 20000) begin
         @(negedge clk);
         g++;
      end
      if (cyc != k) chk("cycle_wait", cyc, k);
   endtask

   task automatic load_main;
      for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
      mem[0] = 16'h1804;
      mem[1] = 16'h0801;
      mem[2] = 16'h1802;
      mem[3] = 16'h1001;
      mem[4] = 16'h2001;
      mem[5] = 16'h0000;
   endtask

   initial begin
      load_main();
      repeat (2) @(posedge clk);

      do_reset(1'b1);
      at_cyc(0);
      chk("rst_addr", prog_addr, 0);
      chk("rst_cnt", instr_count, 0);
      chk("rst_strobes", {sel_a, sel_b, op_sub, wr_acc, rd_ram, wr_ram, halted, illegal_op}, 0);
      at_cyc(2);
      chk("ldi_wr_acc", wr_acc, 1);
      chk("ldi_sel_a", sel_a, 1);
      chk("ldi_operand", operand, 4);
      at_cyc(4);
      chk("sto_wr_ram", wr_ram, 1);
      chk("sto_addr", prog_addr, 2);
      at_cyc(11);
      chk("pre_halt", halted, 0);
      at_cyc(12);
      chk("halted_c12", halted, 1);
      chk("halt_cnt", instr_count, 6);
      chk("halt_addr", prog_addr, 5);
      at_cyc(20);
      chk("halt_hold_addr", prog_addr, 5);

      do_reset(1'b0);
      at_cyc(0);
      chk("rst_from_halt", halted, 0);
      at_cyc(4);
      chk("run0_addr", prog_addr, 0);
      chk("run0_cnt", instr_count, 0);
      chk("run0_wr_acc", wr_acc, 0);
      run = 1'b1;
      at_cyc(5);
      chk("run1_c5", wr_acc, 0);
      at_cyc(6);
      chk("run1_c6", wr_acc, 1);
      at_cyc(20);

      do_reset(1'b1);
      at_cyc(3);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midexec_wr_ram", wr_ram, 0);
      chk("midexec_cnt", instr_count, 0);
      chk("midexec_addr", prog_addr, 0);
      at_cyc(14);

      for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
      mem[0] = 16'hF805;
      do_reset(1'b1);
      at_cyc(2);
      chk("ill_pulse", illegal_op, 1);
      chk("ill_strobes", {wr_acc, rd_ram, wr_ram}, 0);
      chk("ill_addr", prog_addr, 1);
      chk("ill_cnt", instr_count, 1);
      at_cyc(3);
      chk("ill_end", illegal_op, 0);
      at_cyc(6);

      mem[0] = 16'h2807;
      mem[1] = 16'h3003;
      mem[2] = 16'h3801;
      mem[3] = 16'h4000;
      mem[4] = 16'h17FF;
      mem[5] = 16'h0800;
      mem[6] = 16'h0000;
      do_reset(1'b1);
      at_cyc(4);
      chk("sub_ctl", {sel_a, sel_b, op_sub, rd_ram}, 5'b10_0_1_1);
      at_cyc(6);
      chk("subi_ctl", {sel_a, sel_b, op_sub, rd_ram}, 5'b10_1_1_0);
      at_cyc(16);
      chk("mix_cnt", instr_count, 7);

      for (int i = 0; i < 2048; i++) mem[i] = 16'h2801;
      do_reset(1'b1);
      at_cyc(4094);
      chk("wrap_top", prog_addr, 2047);
      at_cyc(4096);
      chk("wrap_zero", prog_addr, 0);
      chk("wrap_cnt", instr_count, 2048);
      chk("wrap_wr_acc", wr_acc, 1);
      at_cyc(4100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
